// File: rtl/riscv_ifu_align.sv
// riscv_ifu_align
// Realigns 32-bit word-aligned fetch responses into whole RV32 / RVC
// instructions for decode. A single halfword buffer carries the upper half of
// the last word so that compressed pairs and word-straddling 32-bit
// instructions can be emitted one per cycle. Redirects, including redirects
// to an odd halfword, flush the buffer and restart the stream.
module riscv_ifu_align #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  // fetch response side
  input  logic        fetch_vld,
  input  logic [31:0] fetch_addr,
  input  logic [31:0] fetch_data,
  output logic        fetch_rdy,
  // redirect
  input  logic        redirect_vld,
  input  logic [31:0] redirect_addr,
  // decode side
  output logic        ifu_vld,
  output logic [31:0] ifu_addr,
  output logic [31:0] ifu_data,
  input  logic        ifu_rdy
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  // r_pc is the halfword address of the next instruction to emit. Whenever
  // r_hb_vld is set, r_hb_data is the halfword at r_pc and r_pc[1] is 1.
  logic [31:1] r_pc;
  logic [15:0] r_hb_data;
  logic        r_hb_vld;

  // Output register presented to decode.
  logic        r_ifu_vld;
  logic [31:0] r_ifu_addr;
  logic [31:0] r_ifu_data;

  // ---------------------------------------------------------------------------
  // Decoded conditions
  // ---------------------------------------------------------------------------
  logic        w_slot_free;   // output register may be overwritten this cycle
  logic        w_hb_is_rvc;   // buffered half is a complete 16-bit instruction
  logic        w_drain;       // buffered compressed half must be emitted first
  logic [31:2] w_exp_word;    // word address the stream needs next
  logic        w_stale;       // presented word is not the one we need
  logic        w_lo_is_rvc;   // lower half of the presented word is compressed
  logic        w_fetch_rdy;
  logic        w_take;        // in-sequence word accepted and consumed

  // Next-state values for the stream (ignoring reset and redirect).
  logic [31:1] w_pc_nxt;
  logic [15:0] w_hb_data_nxt;
  logic        w_hb_vld_nxt;
  logic        w_emit;
  logic [31:0] w_emit_addr;
  logic [31:0] w_emit_data;

  assign w_slot_free = !r_ifu_vld || ifu_rdy;
  assign w_hb_is_rvc = (r_hb_data[1:0] != 2'b11);
  assign w_drain     = r_hb_vld && w_hb_is_rvc;
  assign w_lo_is_rvc = (fetch_data[1:0] != 2'b11);

  // A buffered half always sits in the upper half of the word at r_pc, so the
  // next needed word is one past it; otherwise it is the word holding r_pc.
  assign w_exp_word = r_hb_vld ? (r_pc[31:2] + 30'd1) : r_pc[31:2];
  assign w_stale    = (fetch_addr[31:2] != w_exp_word);

  // Fetch handshake: a redirect swallows whatever is presented, a drain cycle
  // blocks fetch, and stale words are always swallowed so fetch cannot stall.
  always_comb begin
    if (redirect_vld) begin
      w_fetch_rdy = 1'b1;
    end else if (w_drain) begin
      w_fetch_rdy = 1'b0;
    end else begin
      w_fetch_rdy = w_slot_free || w_stale;
    end
  end

  assign fetch_rdy = w_fetch_rdy;

  // Only an in-sequence word outside a redirect changes the stream; a
  // non-stale word is only accepted when the output slot is free.
  assign w_take = fetch_vld && w_fetch_rdy && !redirect_vld && !w_drain && !w_stale;

  // Compute the stream update and the instruction (if any) emitted this cycle.
  // NOTE: every signal written here gets a default first, so no path through
  // the if/else chain leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_pc_nxt      = r_pc;
    w_hb_data_nxt = r_hb_data;
    w_hb_vld_nxt  = r_hb_vld;
    w_emit        = 1'b0;
    w_emit_addr   = {r_pc, 1'b0};
    w_emit_data   = 32'h0000_0000;

    if (w_drain) begin
      // Buffered compressed half goes out on its own; the fetch word waits.
      if (w_slot_free) begin
        w_emit       = 1'b1;
        w_emit_data  = {16'h0000, r_hb_data};
        w_pc_nxt     = r_pc + 31'd1;
        w_hb_vld_nxt = 1'b0;
      end
    end else if (w_take) begin
      if (r_hb_vld) begin
        // 32-bit instruction straddling the word boundary.
        w_emit        = 1'b1;
        w_emit_data   = {fetch_data[15:0], r_hb_data};
        w_pc_nxt      = r_pc + 31'd2;
        w_hb_data_nxt = fetch_data[31:16];
      end else if (r_pc[1]) begin
        // Entered at an upper half after a redirect: the lower half is not
        // part of the stream, keep only the upper half.
        w_hb_data_nxt = fetch_data[31:16];
        w_hb_vld_nxt  = 1'b1;
      end else if (w_lo_is_rvc) begin
        // Compressed in the lower half; upper half is buffered for later.
        w_emit        = 1'b1;
        w_emit_data   = {16'h0000, fetch_data[15:0]};
        w_pc_nxt      = r_pc + 31'd1;
        w_hb_data_nxt = fetch_data[31:16];
        w_hb_vld_nxt  = 1'b1;
      end else begin
        // Aligned 32-bit instruction fills the whole word.
        w_emit      = 1'b1;
        w_emit_data = fetch_data;
        w_pc_nxt    = r_pc + 31'd2;
      end
    end
  end

  // Stream state update: reset, then redirect, then normal progress.
  // NOTE: non-blocking assignments so every register samples pre-edge values
  // and statement order inside the block cannot change the result.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc      <= RESET_PC[31:1];
      r_hb_data <= 16'h0000;
      r_hb_vld  <= 1'b0;
    end else if (redirect_vld) begin
      r_pc     <= redirect_addr[31:1];
      r_hb_vld <= 1'b0;
    end else begin
      r_pc      <= w_pc_nxt;
      r_hb_data <= w_hb_data_nxt;
      r_hb_vld  <= w_hb_vld_nxt;
    end
  end

  // Output register: loads on emit, empties when a free slot has nothing new,
  // holds under backpressure, and is invalidated by redirect unconditionally.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ifu_vld  <= 1'b0;
      r_ifu_addr <= 32'h0000_0000;
      r_ifu_data <= 32'h0000_0000;
    end else if (redirect_vld) begin
      r_ifu_vld <= 1'b0;
    end else begin
      if (w_slot_free) begin
        r_ifu_vld <= w_emit;
      end
      if (w_emit) begin
        r_ifu_addr <= w_emit_addr;
        r_ifu_data <= w_emit_data;
      end
    end
  end

  assign ifu_vld  = r_ifu_vld;
  assign ifu_addr = r_ifu_addr;
  assign ifu_data = r_ifu_data;

endmodule

// File: tb/tb_riscv_ifu_align.sv
// tb_riscv_ifu_align
// Directed scenarios for the realignment stage followed by a randomized run
// against an instruction-walk reference model over a halfword memory image.
module tb_riscv_ifu_align;

  logic        clock = 1'b0;
  logic        reset;
  logic        fetch_vld;
  logic [31:0] fetch_addr;
  logic [31:0] fetch_data;
  logic        fetch_rdy;
  logic        redirect_vld;
  logic [31:0] redirect_addr;
  logic        ifu_vld;
  logic [31:0] ifu_addr;
  logic [31:0] ifu_data;
  logic        ifu_rdy;

  int n_checks = 0;
  int n_errors = 0;

  riscv_ifu_align #(.RESET_PC(32'h0000_0000)) dut (
    .clock        (clock),
    .reset        (reset),
    .fetch_vld    (fetch_vld),
    .fetch_addr   (fetch_addr),
    .fetch_data   (fetch_data),
    .fetch_rdy    (fetch_rdy),
    .redirect_vld (redirect_vld),
    .redirect_addr(redirect_addr),
    .ifu_vld      (ifu_vld),
    .ifu_addr     (ifu_addr),
    .ifu_data     (ifu_data),
    .ifu_rdy      (ifu_rdy)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  // Apply inputs shortly after a rising edge and let combinational paths settle.
  task automatic drive(input logic fv, input logic [31:0] fa, input logic [31:0] fd,
                       input logic rv, input logic [31:0] ra, input logic ir);
    fetch_vld     = fv;
    fetch_addr    = fa;
    fetch_data    = fd;
    redirect_vld  = rv;
    redirect_addr = ra;
    ifu_rdy       = ir;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input logic ir);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, ir);
  endtask

  task automatic redir(input logic [31:0] ra);
    drive(1'b0, 32'h0, 32'h0, 1'b1, ra, 1'b1);
    tick();
    check("redir.vld", ifu_vld, 1'b0);
  endtask

  task automatic expect_out(input string tag, input logic [31:0] a, input logic [31:0] d);
    check({tag, ".vld"}, ifu_vld, 1'b1);
    check({tag, ".addr"}, ifu_addr, a);
    check({tag, ".data"}, ifu_data, d);
  endtask

  // Reference memory image and instruction walk.
  logic [15:0] mem [1024];

  function automatic logic [15:0] mh(input logic [31:0] a);
    return mem[a[10:1]];
  endfunction

  initial begin
    logic [31:0] m_pc;
    logic [29:0] ptr;
    logic        hold;
    logic [31:0] h_addr, h_data;
    logic [31:0] exp_d, ra, fa, fd;
    logic [15:0] h0;
    logic        rv, fv, ir, stale;
    int          xfers;

    // ---------------- reset ----------------
    idle(1'b1);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    check("rst.vld", ifu_vld, 1'b0);
    check("rst.addr", ifu_addr, 32'h0);
    check("rst.data", ifu_data, 32'h0);

    // ---------------- aligned 32-bit stream ----------------
    drive(1'b1, 32'h0, 32'h0000_0013, 1'b0, 32'h0, 1'b1);
    check("t1.rdy", fetch_rdy, 1'b1);
    tick();
    expect_out("t1.a", 32'h0, 32'h0000_0013);
    drive(1'b1, 32'h4, 32'h0010_0093, 1'b0, 32'h0, 1'b1);
    tick();
    expect_out("t1.b", 32'h4, 32'h0010_0093);
    idle(1'b1);
    tick();
    check("t1.empty", ifu_vld, 1'b0);

    // ---------------- two compressed in one word ----------------
    redir(32'h0);
    drive(1'b1, 32'h0, 32'h4505_0001, 1'b0, 32'h0, 1'b1);
    tick();
    expect_out("t2.a", 32'h0, 32'h0000_0001);
    drive(1'b1, 32'h4, 32'h0000_0013, 1'b0, 32'h0, 1'b1);
    check("t2.drain_rdy", fetch_rdy, 1'b0);
    tick();
    expect_out("t2.b", 32'h2, 32'h0000_4505);
    check("t2.rdy_after", fetch_rdy, 1'b1);
    tick();
    expect_out("t2.c", 32'h4, 32'h0000_0013);

    // ---------------- straddle ----------------
    redir(32'h0);
    drive(1'b1, 32'h0, 32'h0093_0001, 1'b0, 32'h0, 1'b1);
    tick();
    expect_out("t3.a", 32'h0, 32'h0000_0001);
    drive(1'b1, 32'h4, 32'h0001_0010, 1'b0, 32'h0, 1'b1);
    check("t3.rdy", fetch_rdy, 1'b1);
    tick();
    expect_out("t3.b", 32'h2, 32'h0010_0093);
    idle(1'b1);
    tick();
    expect_out("t3.c", 32'h6, 32'h0000_0001);
    drive(1'b1, 32'h8, 32'h0000_0013, 1'b0, 32'h0, 1'b1);
    tick();
    expect_out("t3.d", 32'h8, 32'h0000_0013);

    // ---------------- backpressure ----------------
    redir(32'h0);
    drive(1'b1, 32'h0, 32'h0000_0013, 1'b0, 32'h0, 1'b1);
    tick();
    expect_out("t4.a", 32'h0, 32'h0000_0013);
    drive(1'b1, 32'h4, 32'h0010_0093, 1'b0, 32'h0, 1'b0);
    check("t4.rdy0", fetch_rdy, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("t4.hold", 32'h0, 32'h0000_0013);
      check("t4.rdy_hold", fetch_rdy, 1'b0);
    end
    drive(1'b1, 32'h40, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0);
    check("t4.stale_rdy", fetch_rdy, 1'b1);
    tick();
    expect_out("t4.stale_hold", 32'h0, 32'h0000_0013);
    drive(1'b1, 32'h4, 32'h0010_0093, 1'b0, 32'h0, 1'b1);
    check("t4.rdy1", fetch_rdy, 1'b1);
    tick();
    expect_out("t4.b", 32'h4, 32'h0010_0093);
    idle(1'b1);
    tick();
    check("t4.empty", ifu_vld, 1'b0);

    // ---------------- redirect to odd halfword ----------------
    drive(1'b1, 32'h100, 32'h0000_0013, 1'b1, 32'h102, 1'b1);
    check("t5.redir_rdy", fetch_rdy, 1'b1);
    tick();
    check("t5.vld0", ifu_vld, 1'b0);
    drive(1'b1, 32'hFC, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1);
    check("t5.stale_rdy", fetch_rdy, 1'b1);
    tick();
    check("t5.vld1", ifu_vld, 1'b0);
    drive(1'b1, 32'h100, 32'h0001_0513, 1'b0, 32'h0, 1'b1);
    tick();
    check("t5.vld2", ifu_vld, 1'b0);
    drive(1'b1, 32'h104, 32'h0000_00A0, 1'b0, 32'h0, 1'b1);
    check("t5.drain_rdy", fetch_rdy, 1'b0);
    tick();
    expect_out("t5.a", 32'h102, 32'h0000_0001);
    tick();
    expect_out("t5.b", 32'h104, 32'h0000_00A0);
    idle(1'b1);
    tick();
    expect_out("t5.c", 32'h106, 32'h0000_0000);

    // ---------------- redirect under backpressure ----------------
    redir(32'h0);
    drive(1'b1, 32'h0, 32'h0000_0013, 1'b0, 32'h0, 1'b1);
    tick();
    expect_out("t7.a", 32'h0, 32'h0000_0013);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h40, 1'b0);
    tick();
    check("t7.vld", ifu_vld, 1'b0);

    // ---------------- pc wrap ----------------
    redir(32'hFFFF_FFFF);
    drive(1'b1, 32'hFFFF_FFFC, 32'h0001_0000, 1'b0, 32'h0, 1'b1);
    tick();
    check("wrap.vld0", ifu_vld, 1'b0);
    drive(1'b1, 32'h0, 32'h0000_0013, 1'b0, 32'h0, 1'b1);
    check("wrap.drain_rdy", fetch_rdy, 1'b0);
    tick();
    expect_out("wrap.a", 32'hFFFF_FFFE, 32'h0000_0001);
    tick();
    expect_out("wrap.b", 32'h0, 32'h0000_0013);

    // ---------------- reset mid-straddle ----------------
    redir(32'h0);
    drive(1'b1, 32'h0, 32'h0093_0001, 1'b0, 32'h0, 1'b0);
    tick();
    expect_out("t6.a", 32'h0, 32'h0000_0001);
    idle(1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6.vld", ifu_vld, 1'b0);
    check("t6.addr", ifu_addr, 32'h0);
    check("t6.data", ifu_data, 32'h0);
    drive(1'b1, 32'h0, 32'h0000_0013, 1'b0, 32'h0, 1'b1);
    tick();
    expect_out("t6.b", 32'h0, 32'h0000_0013);

    // ---------------- randomized run ----------------
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 16'($urandom);
      if ($urandom_range(0, 1) == 0) mem[i][1:0] = 2'b11;
    end
    ra = $urandom;
    redir(ra);
    m_pc  = ra & ~32'd1;
    ptr   = ra[31:2];
    hold  = 1'b0;
    h_addr = 32'h0;
    h_data = 32'h0;
    xfers = 0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      rv = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 2) == 0) ra = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      else ra = $urandom;
      fv    = ($urandom_range(0, 3) != 0);
      stale = ($urandom_range(0, 7) == 0);
      if (stale) begin
        fa = {ptr + 30'($urandom_range(1, 1000)), 2'($urandom)};
        fd = $urandom;
      end else begin
        fa = {ptr, 2'($urandom)};
        fd = {mh({ptr, 2'b10}), mh({ptr, 2'b00})};
      end
      ir = ($urandom_range(0, 3) != 0);
      drive(fv, fa, fd, rv, ra, ir);

      if (hold) begin
        check("rnd.hold.vld", ifu_vld, 1'b1);
        check("rnd.hold.addr", ifu_addr, h_addr);
        check("rnd.hold.data", ifu_data, h_data);
      end

      if (ifu_vld && ifu_rdy) begin
        h0 = mh(m_pc);
        if (h0[1:0] != 2'b11) exp_d = {16'h0000, h0};
        else exp_d = {mh(m_pc + 32'd2), h0};
        check("rnd.addr", ifu_addr, m_pc);
        check("rnd.data", ifu_data, exp_d);
        m_pc = m_pc + ((h0[1:0] != 2'b11) ? 32'd2 : 32'd4);
        xfers++;
      end

      if (rv) begin
        m_pc = ra & ~32'd1;
        ptr  = ra[31:2];
      end else if (fv && fetch_rdy && !stale) begin
        ptr = ptr + 30'd1;
      end

      hold   = ifu_vld && !ifu_rdy && !rv;
      h_addr = ifu_addr;
      h_data = ifu_data;
      tick();
    end
    check("rnd.progress", 32'(xfers >= 300), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
